// File: rtl/id_ex.sv
// Decode-to-exec pipeline register with stall, flush and bubble handling.
// Killed or empty slots always carry a canonical NOP with write-enable and valid low.
module id_ex #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_ex_instr_addr_in,
  input  logic [31:0] id_ex_instr_in,
  input  logic [4:0]  id_ex_write_addr_in,
  input  logic [4:0]  id_ex_reg1_addr_in,
  input  logic [4:0]  id_ex_reg2_addr_in,
  input  logic [31:0] id_ex_op1_in,
  input  logic [31:0] id_ex_op2_in,
  input  logic [31:0] id_ex_jump_op1_in,
  input  logic [31:0] id_ex_jump_op2_in,
  input  logic        id_ex_wen_in,
  input  logic        id_ex_valid_in,
  input  logic        id_ex_hold_in,
  input  logic        id_ex_flush_in,
  output logic [31:0] id_ex_instr_addr_out,
  output logic [31:0] id_ex_instr_out,
  output logic [4:0]  id_ex_write_addr_out,
  output logic [4:0]  id_ex_reg1_addr_out,
  output logic [4:0]  id_ex_reg2_addr_out,
  output logic [31:0] id_ex_op1_out,
  output logic [31:0] id_ex_op2_out,
  output logic [31:0] id_ex_jump_op1_out,
  output logic [31:0] id_ex_jump_op2_out,
  output logic        id_ex_wen_out,
  output logic        id_ex_valid_out,
  output logic [15:0] id_ex_flush_cnt_out
);

  typedef struct packed {
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic [4:0]  write_addr;
    logic [4:0]  reg1_addr;
    logic [4:0]  reg2_addr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] jump_op1;
    logic [31:0] jump_op2;
    logic        wen;
    logic        valid;
  } slot_t;

  slot_t       slot_q, slot_d;
  slot_t       nop_slot_s, in_slot_s;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    nop_slot_s       = '0;
    nop_slot_s.instr = NOP_INSTR;
  end

  always_comb begin
    in_slot_s.instr_addr = id_ex_instr_addr_in;
    in_slot_s.instr      = id_ex_instr_in;
    in_slot_s.write_addr = id_ex_write_addr_in;
    in_slot_s.reg1_addr  = id_ex_reg1_addr_in;
    in_slot_s.reg2_addr  = id_ex_reg2_addr_in;
    in_slot_s.op1        = id_ex_op1_in;
    in_slot_s.op2        = id_ex_op2_in;
    in_slot_s.jump_op1   = id_ex_jump_op1_in;
    in_slot_s.jump_op2   = id_ex_jump_op2_in;
    in_slot_s.wen        = id_ex_wen_in;
    in_slot_s.valid      = 1'b1;
  end

  // Flush beats hold; only a flush of a real instruction is counted.
  always_comb begin
    slot_d      = slot_q;
    flush_cnt_d = flush_cnt_q;
    if (id_ex_flush_in) begin
      slot_d = nop_slot_s;
      if (slot_q.valid && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_d = flush_cnt_q + 16'd1;
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end else if (id_ex_hold_in) begin
      slot_d = slot_q;
    end else if (id_ex_valid_in) begin
      slot_d = in_slot_s;
    end else begin
      slot_d = nop_slot_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= nop_slot_s;
      flush_cnt_q <= 16'd0;
    end else begin
      slot_q      <= slot_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign id_ex_instr_addr_out = slot_q.instr_addr;
  assign id_ex_instr_out      = slot_q.instr;
  assign id_ex_write_addr_out = slot_q.write_addr;
  assign id_ex_reg1_addr_out  = slot_q.reg1_addr;
  assign id_ex_reg2_addr_out  = slot_q.reg2_addr;
  assign id_ex_op1_out        = slot_q.op1;
  assign id_ex_op2_out        = slot_q.op2;
  assign id_ex_jump_op1_out   = slot_q.jump_op1;
  assign id_ex_jump_op2_out   = slot_q.jump_op2;
  assign id_ex_wen_out        = slot_q.wen;
  assign id_ex_valid_out      = slot_q.valid;
  assign id_ex_flush_cnt_out  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex.sv
// Directed bench for id_ex: expected slot/counter pushed to a scoreboard at drive time,
// popped and compared one edge later.
module tb_id_ex;

  typedef struct packed {
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic [4:0]  write_addr;
    logic [4:0]  reg1_addr;
    logic [4:0]  reg2_addr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] jump_op1;
    logic [31:0] jump_op2;
    logic        wen;
    logic        valid;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold_s = 1'b0;
  logic        flush_s = 1'b0;
  slot_t       din = '0;
  slot_t       dout;
  logic [31:0] o_ia, o_in, o_op1, o_op2, o_j1, o_j2;
  logic [4:0]  o_wa, o_r1, o_r2;
  logic        o_wen, o_valid;
  logic [15:0] o_cnt;

  int checks = 0;
  int failures = 0;

  slot_t       q_slot[$];
  logic [15:0] q_cnt[$];
  string       q_tag[$];

  always #5 clk = ~clk;

  id_ex dut (
    .clk(clk), .rst(rst),
    .id_ex_instr_addr_in(din.instr_addr), .id_ex_instr_in(din.instr),
    .id_ex_write_addr_in(din.write_addr), .id_ex_reg1_addr_in(din.reg1_addr),
    .id_ex_reg2_addr_in(din.reg2_addr), .id_ex_op1_in(din.op1), .id_ex_op2_in(din.op2),
    .id_ex_jump_op1_in(din.jump_op1), .id_ex_jump_op2_in(din.jump_op2),
    .id_ex_wen_in(din.wen), .id_ex_valid_in(din.valid),
    .id_ex_hold_in(hold_s), .id_ex_flush_in(flush_s),
    .id_ex_instr_addr_out(o_ia), .id_ex_instr_out(o_in), .id_ex_write_addr_out(o_wa),
    .id_ex_reg1_addr_out(o_r1), .id_ex_reg2_addr_out(o_r2), .id_ex_op1_out(o_op1),
    .id_ex_op2_out(o_op2), .id_ex_jump_op1_out(o_j1), .id_ex_jump_op2_out(o_j2),
    .id_ex_wen_out(o_wen), .id_ex_valid_out(o_valid), .id_ex_flush_cnt_out(o_cnt)
  );

  assign dout = {o_ia, o_in, o_wa, o_r1, o_r2, o_op1, o_op2, o_j1, o_j2, o_wen, o_valid};

  function automatic slot_t mk(input logic [31:0] ia, input logic [31:0] ins,
                               input logic [4:0] wa, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [31:0] o1, input logic [31:0] o2,
                               input logic [31:0] j1, input logic [31:0] j2,
                               input logic wen, input logic valid);
    slot_t s;
    s = {ia, ins, wa, r1, r2, o1, o2, j1, j2, wen, valid};
    return s;
  endfunction

  function automatic slot_t rnd_slot();
    slot_t s;
    s.instr_addr = $urandom;  s.instr = $urandom;
    s.write_addr = 5'($urandom); s.reg1_addr = 5'($urandom); s.reg2_addr = 5'($urandom);
    s.op1 = $urandom; s.op2 = $urandom; s.jump_op1 = $urandom; s.jump_op2 = $urandom;
    s.wen = 1'($urandom); s.valid = 1'b1;
    return s;
  endfunction

  // One clock: drive at negedge, record expectation, compare just after the rising edge.
  task automatic step(input logic r, input logic f, input logic h, input slot_t in_s,
                      input slot_t exp_s, input logic [15:0] exp_c, input string tag);
    slot_t       es;
    logic [15:0] ec;
    string       t;
    @(negedge clk);
    rst = r; flush_s = f; hold_s = h; din = in_s;
    q_slot.push_back(exp_s); q_cnt.push_back(exp_c); q_tag.push_back(tag);
    @(posedge clk);
    #1;
    es = q_slot.pop_front(); ec = q_cnt.pop_front(); t = q_tag.pop_front();
    checks++;
    assert (dout === es) else begin
      failures++;
      $error("FAIL %s slot observed=%h expected=%h", t, dout, es);
    end
    checks++;
    assert (o_cnt === ec) else begin
      failures++;
      $error("FAIL %s flush_cnt observed=%h expected=%h", t, o_cnt, ec);
    end
  endtask

  slot_t nop_s, a_s, b_s, c_s, bub_s;

  initial begin
    nop_s = mk(32'd0, 32'h0000_0013, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    a_s   = mk(32'h0000_0100, 32'h0050_0093, 5'd1, 5'd0, 5'd0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b1, 1'b1);
    b_s   = mk(32'h0000_0104, 32'h0020_8133, 5'd2, 5'd1, 5'd2, 32'd7, 32'd9, 32'h104, 32'h8, 1'b1, 1'b1);
    c_s   = mk(32'h0000_0108, 32'h0080_00EF, 5'd3, 5'd4, 5'd5, 32'hDEAD_BEEF, 32'h1234_5678,
               32'h108, 32'h10, 1'b0, 1'b1);
    bub_s = mk(32'hFFFF_FFFC, 32'h0010_0093, 5'd31, 5'd30, 5'd29, 32'h11, 32'h22, 32'h33, 32'h44,
               1'b1, 1'b0);

    step(1'b1, 1'($urandom), 1'($urandom), rnd_slot(), nop_s, 16'd0, "reset1");
    step(1'b1, 1'($urandom), 1'($urandom), rnd_slot(), nop_s, 16'd0, "reset2");

    step(1'b0, 1'b0, 1'b0, a_s, a_s, 16'd0, "pass_a");
    step(1'b0, 1'b0, 1'b0, c_s, c_s, 16'd0, "pass_c_wen0");
    step(1'b0, 1'b0, 1'b0, a_s, a_s, 16'd0, "load_a");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, b_s, a_s, 16'd0, "hold_a");
    step(1'b0, 1'b0, 1'b0, b_s, b_s, 16'd0, "after_hold_b");

    step(1'b0, 1'b1, 1'b1, c_s, nop_s, 16'd1, "flush_over_hold");
    step(1'b0, 1'b1, 1'b0, c_s, nop_s, 16'd1, "flush_again");
    step(1'b0, 1'b0, 1'b1, c_s, nop_s, 16'd1, "hold_nop");

    step(1'b0, 1'b0, 1'b0, a_s, a_s, 16'd1, "load_a2");
    step(1'b0, 1'b0, 1'b0, bub_s, nop_s, 16'd1, "bubble");

    step(1'b0, 1'b0, 1'b0, b_s, b_s, 16'd1, "load_b2");
    step(1'b0, 1'b1, 1'b0, c_s, nop_s, 16'd2, "flush_b2");

    // Reaching 16'hFFFE by real flush pairs would take ~131k cycles; deposit it instead.
    step(1'b0, 1'b0, 1'b0, a_s, a_s, 16'd2, "load_a3");
    force dut.flush_cnt_q = 16'hFFFE;
    #1;
    release dut.flush_cnt_q;
    step(1'b0, 1'b1, 1'b0, b_s, nop_s, 16'hFFFF, "sat_reach");
    step(1'b0, 1'b0, 1'b0, c_s, c_s, 16'hFFFF, "sat_load");
    step(1'b0, 1'b1, 1'b0, b_s, nop_s, 16'hFFFF, "sat_stay");
    step(1'b0, 1'b0, 1'b0, a_s, a_s, 16'hFFFF, "sat_load2");
    step(1'b1, 1'b1, 1'b1, b_s, nop_s, 16'd0, "reset_over_flush");
    step(1'b0, 1'b0, 1'b0, b_s, b_s, 16'd0, "post_reset_b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex.md
# id_ex

Pipeline register between the decode stage and the `exec` stage. It captures the decoded instruction, register addresses, operands, jump operands and write-enable each cycle and presents them to `exec` one cycle later. It supports stall (hold), flush on a taken jump from `exec`, and bubble insertion. A flush or bubble always delivers a canonical NOP, so `exec` never writes back or jumps on a killed slot.

## Interface
- `NOP_INSTR`, default `32'h0000_0013` (addi x0,x0,0): instruction word driven on reset, flush or bubble.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous reset, active-high.
- `id_ex_instr_addr_in` input 32: PC of the decoded instruction.
- `id_ex_instr_in` input 32: decoded instruction word.
- `id_ex_write_addr_in` input 5: rd.
- `id_ex_reg1_addr_in` input 5: rs1.
- `id_ex_reg2_addr_in` input 5: rs2.
- `id_ex_op1_in` input 32: operand 1.
- `id_ex_op2_in` input 32: operand 2.
- `id_ex_jump_op1_in` input 32: jump base.
- `id_ex_jump_op2_in` input 32: jump offset.
- `id_ex_wen_in` input 1: register write enable.
- `id_ex_valid_in` input 1: decode presents a real instruction this cycle.
- `id_ex_hold_in` input 1: stall; keep the current contents.
- `id_ex_flush_in` input 1: kill the current contents; driven by the exec jump flag.
- `id_ex_instr_addr_out`, `id_ex_instr_out`, `id_ex_write_addr_out`, `id_ex_reg1_addr_out`, `id_ex_reg2_addr_out`, `id_ex_op1_out`, `id_ex_op2_out`, `id_ex_jump_op1_out`, `id_ex_jump_op2_out`, `id_ex_wen_out` output (widths as inputs): registered copies fed to exec.
- `id_ex_valid_out` output 1: the slot holds a real instruction.
- `id_ex_flush_cnt_out` output 16: count of flushes that killed a valid slot; saturates at 16'hFFFF.

## Operation
- All outputs are flops. There is no combinational path from input to output.
- Per-cycle update, in priority order:
  1. `rst`: load the NOP slot and clear the counter.
  2. `id_ex_flush_in`: load the NOP slot. If `id_ex_valid_out` was 1, increment the counter, saturating.
  3. `id_ex_hold_in`: keep every output unchanged.
  4. `id_ex_valid_in`=1: capture all inputs. `valid_out` becomes 1.
  5. Otherwise (bubble): load the NOP slot.
- NOP slot contents:
  - `instr_out`=`NOP_INSTR`.
  - `instr_addr`, `write_addr`, `reg1_addr`, `reg2_addr`, `op1`, `op2`, `jump_op1`, `jump_op2` all 0.
  - `wen_out`=0 and `valid_out`=0.
- A captured instruction with `valid_in`=1 passes `wen_in` through unchanged. `wen` is never forced high.
- Flush overrides hold in the same cycle. The killed slot is not retained and the stall does not preserve it.
- The counter increments only on a flush that kills a valid slot. It stays at 16'hFFFF once reached.
- Reset asserted mid-stall or mid-flush wins outright. Outputs reach the NOP slot on the next edge and the counter goes to 0.

## Timing
- Latency: exactly 1 cycle from input to output.
- Throughput: one instruction per cycle when `hold`=0.
- Reset values: every output as in the NOP slot; `flush_cnt_out`=0.
- Flush is sampled at edge N. From edge N onward the outputs show the NOP slot, so exec sees a NOP in cycle N+1. Decode is responsible for not re-presenting the killed instruction.
- Hold for k cycles: outputs are constant for k cycles. On the first edge with `hold`=0 the block captures the then-current inputs.
- Back-to-back flushes:
  - Each flush loads the NOP slot.
  - Only the first one increments the counter, because the slot is then invalid.

## Test plan
- Reset: assert `rst` for 2 cycles with random inputs.
  - Required: `instr_out`=32'h13, all other data outputs 0, `wen_out`=0, `valid_out`=0, `flush_cnt_out`=0.
- Pass-through: present addi x1,x0,5 (instr 32'h00500093, op1=0, op2=5, `wen`=1, `valid`=1) at edge N.
  - Required: at N+1, the outputs equal the inputs and `valid_out`=1.
- Hold: load instr A, then assert `hold` for 3 cycles while presenting B.
  - Required: the outputs stay A for all 3 cycles.
  - Required: B appears one edge after `hold` deasserts.
- Flush vs hold: load valid A, then assert `flush` and `hold` together.
  - Required: next cycle shows the NOP slot, `valid_out`=0, `flush_cnt_out`=1.
  - Then a second flush: `flush_cnt_out` stays at 1.
- Bubble: `valid_in`=0 with `wen_in`=1 and nonzero operands.
  - Required: next cycle is the NOP slot with `wen_out`=0.
- Counter saturation: preload the counter to 16'hFFFE via 65534 valid-then-flush pairs, then perform 2 more.
  - Required: the counter reads 16'hFFFF and stays there.
  - Then `rst`: the counter reads 0 one cycle later.
